ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter. It sends one command byte to the keyboard (e.g. 0xED set-LEDs,
//  0xF4 enable) over the open-drain ps2_clk/ps2_data lines. Works with the PS/2 receiver that feeds
//  ps2_code/ps2_code_new into ps2_lcd_interface. The receiver must be gated off while busy=1.
//  Runs on the system clock; nominal period is 36 ns (27.78 MHz).
// PARAMETERS
//  INHIBIT_CYCLES  2800     clk cycles ps2_clk is held low before RTS (>=100 us at 36 ns)
//  RTS_CYCLES      56       clk cycles data is low with clock still low, before clock release (~2 us)
//  TIMEOUT_CYCLES  420000   max clk cycles from clock release to ACK (~15 ms); exceeding it -> timeout
// PORTS
//  clk          in   1  system clock
//  rst          in   1  asynchronous, active-high reset
//  tx_data      in   8  byte to send; sampled when tx_start accepted
//  tx_start     in   1  request; accepted only in IDLE (ignored while busy)
//  busy         out  1  high from acceptance until done/error pulse cycle inclusive
//  done         out  1  1-cycle pulse: byte sent and device ACKed
//  ack_err      out  1  1-cycle pulse: data line high at ACK sample
//  timeout      out  1  1-cycle pulse: TIMEOUT_CYCLES exceeded
//  ps2_clk_i    in   1  ps2_clk pad input (async)
//  ps2_data_i   in   1  ps2_data pad input (async)
//  ps2_clk_oe   out  1  1 = drive ps2_clk low; 0 = release (pull-up)
//  ps2_data_oe  out  1  1 = drive ps2_data low; 0 = release
// BEHAVIOUR
//  Reset: state IDLE; busy=done=ack_err=timeout=0; ps2_clk_oe=ps2_data_oe=0 (both lines released).
//   Reset mid-transfer releases both lines in the same cycle (async) and drops the byte.
//  Input conditioning: ps2_clk_i/ps2_data_i pass a 2-flop sync. Then ps2_clk needs 4 equal samples
//   (debounce) before its filtered value changes. clk_fall = 1-cycle pulse on filtered 1->0.
//  Frame latched at accept: {stop=1, parity=~^tx_data (odd), tx_data[7:0] LSB first}; bit_cnt=0.
//  FSM:
//   IDLE    tx_start -> latch frame, busy=1, cnt=0 -> INHIBIT
//   INHIBIT clk_oe=1, data_oe=0; cnt==INHIBIT_CYCLES-1 -> RTS
//   RTS     clk_oe=1, data_oe=1 (start bit); cnt==RTS_CYCLES-1 -> SEND, release clk, tmo_cnt=0
//   SEND    clk_oe=0; on each clk_fall: data_oe <= ~frame[bit_cnt], bit_cnt++
//           falls 1..8 data bits, 9 parity, 10 stop (data_oe=0); after fall 10 -> ACK
//   ACK     on clk_fall (11th): sample filtered data; 0 -> done pulse, 1 -> ack_err pulse -> IDLE
//  Timeout: tmo_cnt counts every cycle in SEND/ACK. tmo_cnt==TIMEOUT_CYCLES-1 -> timeout pulse,
//   release both lines, -> IDLE. Timeout wins over a clk_fall in the same cycle.
//  busy drops the cycle after the done/ack_err/timeout pulse; a tx_start in that pulse cycle is ignored.
//  tx_data changes after acceptance have no effect. Latency from tx_start to first clock release:
//   INHIBIT_CYCLES+RTS_CYCLES+1 cycles. Counters sized by $clog2 of their parameter; no wrap in use.
//  ps2_data_oe only changes in the cycle after clk_fall, which is within the device's clock-low phase.
// STRUCTURE
//  ps2_pkg: typedef enum logic [2:0] {IDLE,INHIBIT,RTS,SEND,ACK} ps2_tx_state_t;
//   constants PS2_CMD_SET_LEDS=8'hED, PS2_CMD_ECHO=8'hEE, PS2_CMD_ENABLE=8'hF4,
//   PS2_CMD_RESET=8'hFF, PS2_ACK=8'hFA.
//  Sub-module ps2_line_sync: 2-flop sync + 4-sample debounce + fall pulse; one instance for clk,
//   one for data (fall unused). The same module is reused by the PS/2 receiver.
// TESTING
//  Bench: device model with pull-up resolution (line = ~oe & ~dev_drive) and a 40 us device clock
//   period. It samples data on rising edges and drives ACK low on the 11th clock.
//  1 tx_data=8'hED, tx_start -> clk low >=2800 cycles, then data low; model reads 0xED, parity=1,
//    stop=1; ACK -> done pulse once, busy low next cycle.
//  2 tx_data=8'hF4 -> model reads 0xF4, parity=0; done=1; ps2_clk_oe/ps2_data_oe both 0 after.
//  3 Model omits ACK (data high on 11th fall) with 8'hEE -> ack_err pulse, done stays 0, lines released.
//  4 Model never clocks after RTS -> timeout pulse exactly TIMEOUT_CYCLES after clock release; IDLE.
//  5 rst=1 during SEND at bit 4 -> both oe=0 immediately, busy=0; next tx_start 8'hFF completes, done=1.
//  6 tx_start pulsed again mid-frame with tx_data=8'h00 -> ignored; model still receives first byte.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 types, command codes and frame helper.
// Used by the host transmitter and the PS/2 receiver path.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_ACK          = 8'hFA;

    // {stop, odd parity, data}; bit 0 goes out first.
    function automatic logic [9:0] ps2_frame(input logic [7:0] d);
        return {1'b1, ~^d, d};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 pad conditioner: 2-flop synchroniser, 4-sample debounce
// and a one-cycle pulse on each filtered falling edge.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic       filt_q, filt_d;
    logic [1:0] cnt_q, cnt_d;
    logic       fall_q, fall_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            cnt_q  <= 2'd0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], line_i};
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
            fall_q <= fall_d;
        end
    end

    // Filter flips only after four consecutive samples disagree with it.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = 2'd0;
        fall_d = 1'b0;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == 2'd3) begin
                filt_d = sync_q[1];
                fall_d = filt_q;
            end else begin
                cnt_d = cnt_q + 2'd1;
            end
        end
    end

    assign level_o = filt_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, then
// clocks out one byte under device clock and checks the ACK bit.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 2800,
    parameter int RTS_CYCLES     = 56,
    parameter int TIMEOUT_CYCLES = 420000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int CMAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int CW   = $clog2(CMAX);
    localparam int TW   = $clog2(TIMEOUT_CYCLES);

    ps2_tx_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [9:0]    frame_q, frame_d;
    logic [3:0]    bit_q, bit_d;
    logic          doe_q, doe_d;

    logic clk_lvl_unused, clk_fall;
    logic data_lvl, data_fall_unused;
    logic tmo_hit;

    ps2_line_sync u_clk_sync (
        .clk    (clk),
        .rst    (rst),
        .line_i (ps2_clk_i),
        .level_o(clk_lvl_unused),
        .fall_o (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk    (clk),
        .rst    (rst),
        .line_i (ps2_data_i),
        .level_o(data_lvl),
        .fall_o (data_fall_unused)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tmo_q   <= '0;
            frame_q <= '0;
            bit_q   <= '0;
            doe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            frame_q <= frame_d;
            bit_q   <= bit_d;
            doe_q   <= doe_d;
        end
    end

    assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        frame_d     = frame_q;
        bit_d       = bit_q;
        doe_d       = doe_q;
        busy        = (state_q != IDLE);
        done        = 1'b0;
        ack_err     = 1'b0;
        timeout     = 1'b0;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tx_start) begin
                    frame_d = ps2_frame(tx_data);
                    bit_d   = 4'd0;
                    cnt_d   = '0;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                cnt_d      = cnt_q + CW'(1);
                if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = RTS;
                end
            end
            RTS: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
                cnt_d       = cnt_q + CW'(1);
                if (cnt_q == CW'(RTS_CYCLES - 1)) begin
                    tmo_d   = '0;
                    doe_d   = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                ps2_data_oe = doe_q;
                tmo_d       = tmo_q + TW'(1);
                if (tmo_hit) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else if (clk_fall) begin
                    doe_d = ~frame_q[bit_q];
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd9) begin
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                ps2_data_oe = doe_q;
                tmo_d       = tmo_q + TW'(1);
                if (tmo_hit) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else if (clk_fall) begin
                    done    = ~data_lvl;
                    ack_err = data_lvl;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
